md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Holds the architectural HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Feeds the 32-bit 2:1 HI/LO result-select mux downstream. That mux drives mfhi/mflo data into the EX result path.
- Drives busy so hazard control stalls dependent md and mfhi/mflo instructions in ID.

---
 rtl/md_unit.sv | 176 +++++++++++++++++
 tb/tb_md_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Executes mult, multu, div, divu, mthi and mtlo.
// The result is computed when the operation is accepted and parked in a shadow
// register; it is committed to HI/LO when the busy window ends.
// Optional feature macro: MD_CANCEL_EN (adds the cancel flush input).
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   res_hi_q;
    logic [XLEN-1:0]   res_lo_q;
    logic              res_we_q;

    logic              kill;
    logic              accept;
    logic              commit;
    logic              wr_mthi;
    logic              wr_mtlo;

    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;
    logic              is_sdiv;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   div_b;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   new_hi;
    logic [XLEN-1:0]   new_lo;

`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave BUSY when the counter has run out or on a flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (kill || (cnt_q == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control decode; starts seen while busy fall through untouched
    always_comb begin
        accept  = 1'b0;
        wr_mthi = 1'b0;
        wr_mtlo = 1'b0;
        commit  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && !kill) begin
                accept  = (op <= OP_DIVU);
                wr_mthi = (op == OP_MTHI);
                wr_mtlo = (op == OP_MTLO);
            end
        end else begin
            commit = !kill && (cnt_q == '0);
        end
    end

    // Result datapath; divide works on magnitudes so the overflow case falls out
    always_comb begin
        prod_s  = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
        prod_u  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        is_sdiv = (op == OP_DIV);
        mag_a   = (is_sdiv && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
        mag_b   = (is_sdiv && b[XLEN-1]) ? (~b + XLEN'(1)) : b;
        div_b   = (mag_b == '0) ? XLEN'(1) : mag_b;
        q_mag   = mag_a / div_b;
        r_mag   = mag_a % div_b;
        quot    = (is_sdiv && (a[XLEN-1] ^ b[XLEN-1])) ? (~q_mag + XLEN'(1)) : q_mag;
        rem     = (is_sdiv && a[XLEN-1]) ? (~r_mag + XLEN'(1)) : r_mag;
        case (op)
            OP_MULT:  {new_hi, new_lo} = prod_s;
            OP_MULTU: {new_hi, new_lo} = prod_u;
            default:  {new_hi, new_lo} = {rem, quot};
        endcase
    end

    // Busy counter: loaded with N-1 on accept, counts down, cleared on flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (kill && (state_q == S_BUSY)) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= op[1] ? DIV_LOAD : MULT_LOAD;
        end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Shadow result captured at accept; divide-by-zero leaves HI/LO alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
        end else if (accept) begin
            res_hi_q <= new_hi;
            res_lo_q <= new_lo;
            res_we_q <= !(op[1] && (b == '0));
        end else if (kill || commit) begin
            res_we_q <= 1'b0;
        end
    end

    // Architectural HI/LO: commit from shadow or direct mthi/mtlo write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (res_we_q) begin
                hi <= res_hi_q;
                lo <= res_lo_q;
            end
        end else begin
            if (wr_mthi) hi <= a;
            if (wr_mtlo) lo <= a;
        end
    end

    // busy is the BUSY state flop itself
    assign busy = (state_q == S_BUSY);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector bench for md_unit (build with MD_CANCEL_EN to cover cancel).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MD_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op for one edge; returns just after that edge
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd6;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[4]  = '{3'd4, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h80000000};
        vecs[5]  = '{3'd3, 32'h00000007, 32'h00000000, 10, 32'h12345678, 32'h80000000};
        vecs[6]  = '{3'd2, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'h80000000};
        vecs[7]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 0,  32'h12345678, 32'hCAFEF00D};
        vecs[8]  = '{3'd6, 32'h00000001, 32'h00000001, 0,  32'h12345678, 32'hCAFEF00D};
        vecs[9]  = '{3'd7, 32'h00000001, 32'h00000001, 0,  32'h12345678, 32'hCAFEF00D};
        vecs[10] = '{3'd3, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        vecs[11] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[12] = '{3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 5,  32'h00000000, 32'h0000000F};
        vecs[13] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[14] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};

        n_checks = 0;
        n_fail   = 0;
        reset  = 1'b0;
        start  = 1'b0;
        op     = 3'd6;
        a      = '0;
        b      = '0;
        cancel = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b1;
        step();

        // Table-driven ops, expectations chain through HI/LO state
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            check($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            step();
        end

        // Start while busy is ignored
        issue(3'd0, 32'd3, 32'd4);
        step();
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 3'd6;
        check("ign_hold_hi", hi, 32'hFFFFFFFF);
        check("ign_hold_lo", lo, 32'h00000003);
        wait_idle(n);
        check("ign_cycles", 32'(n + 2), 32'd5);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd12);
        step();
        check("ign_no_restart", 32'(busy), 32'd0);

        // Start on the commit edge is rejected, accepted one cycle later
        issue(3'd0, 32'd6, 32'd7);
        repeat (4) step();
        check("cc_busy_before", 32'(busy), 32'd1);
        start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
        step();
        start = 1'b0; op = 3'd6;
        check("cc_busy_fall", 32'(busy), 32'd0);
        check("cc_lo", lo, 32'd42);
        step();
        check("cc_lo_still", lo, 32'd42);
        issue(3'd5, 32'hDEADBEEF, 32'd0);
        check("cc_later_lo", lo, 32'hDEADBEEF);
        check("cc_later_busy", 32'(busy), 32'd0);

        // Reset during a divide clears everything immediately
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        step();
        reset = 1'b1;
        repeat (12) step();
        check("rst_after_busy", 32'(busy), 32'd0);
        check("rst_after_hi", hi, 32'h0);
        check("rst_after_lo", lo, 32'h0);

`ifdef MD_CANCEL_EN
        // Cancel mid-divide, cancel with idle start, cancel on commit edge
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (2) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cx_busy", 32'(busy), 32'd0);
        repeat (12) step();
        check("cx_hi", hi, 32'h11);
        check("cx_lo", lo, 32'h22);
        cancel = 1'b1;
        issue(3'd4, 32'h99, 32'd0);
        cancel = 1'b0;
        check("cx_mthi_hi", hi, 32'h11);
        issue(3'd0, 32'd2, 32'd3);
        repeat (4) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cx_commit_busy", 32'(busy), 32'd0);
        check("cx_commit_lo", lo, 32'h22);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
